conv_encoder_k3: RTL and testbench
==================================

// Module: conv_encoder_k3
// PURPOSE
//  Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal); the stage directly upstream of Viterbi_decoding.
//  Accepts one info bit per handshake and emits one 2-bit coded symbol per bit.
//  On frame end, appends K-1 zero tail bits so the trellis terminates in state 0.
//  The output symbol stream connects directly to the decoder's i_valid/i_data.
// PARAMETERS
//  G0       3'b111  generator for o_data[1] (tap order {in, s1, s0})
//  G1       3'b101  generator for o_data[0]
//  TAIL_EN  1       1: append 2 tail symbols after i_last; 0: no tail, state cleared at frame end
// PORTS
//  i_clk     in   1  clock, rising edge
//  i_rst_n   in   1  asynchronous active-low reset
//  i_valid   in   1  upstream info bit valid
//  i_data    in   1  info bit
//  i_last    in   1  qualifies last info bit of frame (sampled with i_valid)
//  o_ready   out  1  encoder accepts i_data this cycle
//  o_valid   out  1  coded symbol valid
//  o_data    out  2  coded symbol {g0_bit, g1_bit}
//  o_last    out  1  final symbol of frame (last tail symbol, or last data symbol if TAIL_EN=0)
//  i_ready   in   1  downstream accepts symbol (tie 1 when driving Viterbi_decoding)
// BEHAVIOUR
//  Reset: o_valid=0, o_data=2'b00, o_last=0, o_ready=0 while i_rst_n=0, shift reg {s1,s0}=2'b00, FSM=IDLE.
//   o_ready rises the first cycle after deassertion.
//  Accept: upstream transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
//  o_ready = (FSM!=TAIL) && (!o_valid || i_ready): single output register; no internal FIFO.
//  Encode on accept, with u=i_data:
//   o_data[1] = ^({u,s1,s0} & G0)
//   o_data[0] = ^({u,s1,s0} & G1)
//   then {s1,s0} <= {u,s1}.
//  Latency: symbol is registered; o_valid is high the cycle after accept.
//  Hold: while o_valid && !i_ready, o_data/o_last stay stable and the shift reg is frozen.
//  Throughput: one symbol/cycle with i_ready=1.
//  FSM:
//   IDLE  -> DATA on first accept.
//   DATA  -> TAIL on accept with i_last (TAIL_EN=1).
//   DATA  -> IDLE on accept with i_last (TAIL_EN=0); that symbol has o_last=1 and {s1,s0} <= 0.
//   TAIL: o_ready=0. Emits tail symbol 0 (u=0), then tail symbol 1 (u=0, o_last=1).
//    Each tail symbol loads only when the output register is free.
//    A 1-bit tail counter selects the symbol.
//   TAIL -> IDLE when tail symbol 1 is loaded; {s1,s0} is then 00.
//  An i_last accept in IDLE is a 1-bit frame: tail rules apply identically.
//  Back-to-back frames: the new frame is accepted the cycle after the FSM returns to IDLE (o_ready high).
//  i_last is ignored unless i_valid && o_ready.
//  Reset mid-frame clears everything asynchronously; the partial frame is discarded and no o_last is emitted.
// STRUCTURE
//  Shared package viterbi_pkg holds:
//   K=3
//   G0_DEF=3'b111, G1_DEF=3'b101
//   typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_e
//   function conv_sym(u, s, g0, g1) returning the 2-bit symbol (reused by the decoder's branch-metric unit)
//  No sub-module: FSM, shift reg, tail counter and output register live in one always_ff.
//  The encode equation lives in a separate always_comb.
// TESTING
//  T1 TAIL_EN=0, bits 1,0,1,0,1,0,1,0 (last on 8th), i_ready=1
//   -> o_data 11,10,00,10,00,10,00,10; o_last on 8th symbol.
//  T2 TAIL_EN=1, bits 0,0,1,0,1,0,0,1
//   -> 00,00,11,10,00,10,11,11, then tail 10,11 with o_last on final 11; o_ready low 2 cycles.
//  T3 Backpressure: T2 stimulus with i_ready toggled 1,0,0,1
//   -> o_data held stable while stalled; identical symbol sequence; no drops or duplicates.
//  T4 Reset pulse after the 3rd accepted bit of T2
//   -> outputs 0 immediately; next frame 1 (last) yields 11,10,11.
//  T5 Back-to-back: frame A=1 (last), then frame B=1,1 (last) with i_valid held high
//   -> 11,10,11(last); 11,01,01,11(last); FSM returns to IDLE between frames.
//  T6 Loopback: encoder -> Viterbi_decoding, random 64-bit frames, i_ready=1
//   -> decoded bits equal source bits; flip one coded bit per frame and the decode still matches.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared convolutional-code definitions used by the K=3 encoder and the Viterbi decoder.
// conv_sym is the single source of the branch symbol for both sides of the link.
package viterbi_pkg;

    localparam int         K      = 3;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_e;

    // Taps are ordered {u, s1, s0}; returns {g0_bit, g1_bit}.
    function automatic logic [1:0] conv_sym(input logic         u,
                                            input logic [K-2:0] s,
                                            input logic [K-1:0] g0,
                                            input logic [K-1:0] g1);
        logic [K-1:0] v;
        v = {u, s};
        return {^(v & g0), ^(v & g1)};
    endfunction

endpackage

// File: rtl/conv_encoder_k3_if.sv
// Info-bit input stream and coded-symbol output stream of the K=3 encoder.
interface conv_encoder_k3_if;
    logic       i_valid;
    logic       i_data;
    logic       i_last;
    logic       o_ready;
    logic       o_valid;
    logic [1:0] o_data;
    logic       o_last;
    logic       i_ready;

    modport slave (input  i_valid, i_data, i_last, i_ready,
                   output o_ready, o_valid, o_data, o_last);
    modport master(output i_valid, i_data, i_last, i_ready,
                   input  o_ready, o_valid, o_data, o_last);
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with a single registered output stage
// and optional 2-symbol zero tail so every frame ends in trellis state 0.
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0      = G0_DEF,
    parameter logic [2:0] G1      = G1_DEF,
    parameter bit         TAIL_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    conv_encoder_k3_if.slave   bus
);

    enc_state_e state_q, state_d;
    logic [1:0] sreg_q, sreg_d;
    logic       tail_q, tail_d;
    logic       vld_q, vld_d;
    logic [1:0] data_q, data_d;
    logic       last_q, last_d;
    logic       run_q;

    logic       out_free;
    logic       ready;
    logic       accept;
    logic       enc_u;
    logic [1:0] enc_sym;

    // run_q keeps o_ready low until the first clock after reset release.
    assign out_free = !vld_q || bus.i_ready;
    assign ready    = run_q && (state_q != TAIL) && out_free;
    assign accept   = bus.i_valid && ready;

    always_comb begin
        enc_u   = (state_q == TAIL) ? 1'b0 : bus.i_data;
        enc_sym = conv_sym(enc_u, sreg_q, G0, G1);
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        data_d  = data_q;
        last_d  = last_q;
        if (state_q == TAIL) begin
            if (out_free) begin
                vld_d  = 1'b1;
                data_d = enc_sym;
                last_d = tail_q;
                sreg_d = {1'b0, sreg_q[1]};
                tail_d = ~tail_q;
                if (tail_q) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                end
            end
        end else if (out_free) begin
            vld_d  = accept;
            last_d = 1'b0;
            if (accept) begin
                data_d  = enc_sym;
                sreg_d  = {bus.i_data, sreg_q[1]};
                state_d = DATA;
                if (bus.i_last) begin
                    if (TAIL_EN) begin
                        state_d = TAIL;
                    end else begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                        sreg_d  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            tail_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = vld_q;
    assign bus.o_data  = data_q;
    assign bus.o_last  = last_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: a tailed instance (a) and an untailed instance (b)
// checked every cycle against a convolution model plus literal symbol sequences.
module tb_conv_encoder_k3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_encoder_k3_if ifa();
    conv_encoder_k3_if ifb();

    conv_encoder_k3 #(.TAIL_EN(1'b1)) dut_a(.i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave));
    conv_encoder_k3 #(.TAIL_EN(1'b0)) dut_b(.i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    bit         fa[$], fb[$];
    logic [2:0] expq_a[$], expq_b[$];
    logic [2:0] log_a[$], log_b[$];
    logic [2:0] e;
    bit         prev_stall_a;
    logic [2:0] prev_a;
    int         n;
    bit         u1, u2;

    int         bp_mode = 0;
    int         bp_idx  = 0;
    logic [3:0] bp_pat  = 4'b1001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Code polynomials 1+D+D^2 and 1+D^2 over the frame's bit history.
    function automatic logic [1:0] ref_sym(input bit u, input bit d1, input bit d2);
        return {u ^ d1 ^ d2, u ^ d2};
    endfunction

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       ifa.i_ready = 1'b1;
            1: begin ifa.i_ready = bp_pat[bp_idx]; bp_idx = (bp_idx + 1) % 4; end
            default: ifa.i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Single compare process: transfers, holds, and model updates for both DUTs.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out_a", {ifa.o_valid, ifa.o_data, ifa.o_last, ifa.o_ready}, 0);
            chk("reset_out_b", {ifb.o_valid, ifb.o_data, ifb.o_last, ifb.o_ready}, 0);
            fa.delete(); fb.delete(); expq_a.delete(); expq_b.delete();
            prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a)
                chk("hold_a", {ifa.o_valid, ifa.o_data, ifa.o_last}, {1'b1, prev_a});
            if (ifa.o_valid && ifa.i_ready) begin
                if (expq_a.size() == 0) chk("extra_sym_a", 1, 0);
                else begin e = expq_a.pop_front(); chk("sym_a", {ifa.o_data, ifa.o_last}, e); end
                log_a.push_back({ifa.o_data, ifa.o_last});
            end
            prev_stall_a = ifa.o_valid && !ifa.i_ready;
            prev_a       = {ifa.o_data, ifa.o_last};
            if (ifb.o_valid && ifb.i_ready) begin
                if (expq_b.size() == 0) chk("extra_sym_b", 1, 0);
                else begin e = expq_b.pop_front(); chk("sym_b", {ifb.o_data, ifb.o_last}, e); end
                log_b.push_back({ifb.o_data, ifb.o_last});
            end
            if (ifa.i_valid && ifa.o_ready) begin
                fa.push_back(ifa.i_data);
                n  = fa.size();
                u1 = (n >= 2) ? fa[n-2] : 1'b0;
                u2 = (n >= 3) ? fa[n-3] : 1'b0;
                expq_a.push_back({ref_sym(fa[n-1], u1, u2), 1'b0});
                if (ifa.i_last) begin
                    expq_a.push_back({ref_sym(1'b0, fa[n-1], u1), 1'b0});
                    expq_a.push_back({ref_sym(1'b0, 1'b0, fa[n-1]), 1'b1});
                    fa.delete();
                end
            end
            if (ifb.i_valid && ifb.o_ready) begin
                fb.push_back(ifb.i_data);
                n  = fb.size();
                u1 = (n >= 2) ? fb[n-2] : 1'b0;
                u2 = (n >= 3) ? fb[n-3] : 1'b0;
                expq_b.push_back({ref_sym(fb[n-1], u1, u2), ifb.i_last});
                if (ifb.i_last) fb.delete();
            end
        end
    end

    task automatic send(input bit which, input bit d, input bit l);
        int k;
        bit rdy;
        k = 0;
        if (which) begin ifb.i_valid = 1'b1; ifb.i_data = d; ifb.i_last = l; end
        else       begin ifa.i_valid = 1'b1; ifa.i_data = d; ifa.i_last = l; end
        forever begin
            @(negedge clk);
            rdy = which ? ifb.o_ready : ifa.o_ready;
            if (rdy) break;
            k++;
            if (k > 100) begin chk("send_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ifa.i_valid = 1'b0; ifa.i_last = 1'b0;
        ifb.i_valid = 1'b0; ifb.i_last = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expq_a.size() != 0 || ifa.o_valid || expq_b.size() != 0 || ifb.o_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", expq_a.size() + expq_b.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input string name, input bit which, input logic [63:0] exp, input int cnt);
        logic [63:0] act;
        int sz;
        act = '0;
        sz  = which ? log_b.size() : log_a.size();
        chk({name, "_len"}, sz, cnt);
        for (int i = 0; i < sz && i < 21; i++)
            act = (act << 3) | {61'd0, (which ? log_b[i] : log_a[i])};
        chk(name, act, exp);
    endtask

    task automatic send_frame(input bit which, input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) send(which, bits[len-1-i], i == len - 1);
    endtask

    logic [15:0] t2_bits = 16'b0010_1001;

    initial begin
        ifa.i_valid = 1'b0; ifa.i_data = 1'b0; ifa.i_last = 1'b0;
        ifb.i_valid = 1'b0; ifb.i_data = 1'b0; ifb.i_last = 1'b0; ifb.i_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_rel0", ifa.o_ready, 0);
        @(negedge clk);
        chk("rdy_rel1", ifa.o_ready, 1);
        @(posedge clk); #1;

        // T1: untailed frame
        log_b.delete();
        send_frame(1'b1, 16'b1010_1010, 8);
        idle(); drain();
        chk_log("t1", 1'b1, {3'b110,3'b100,3'b000,3'b100,3'b000,3'b100,3'b000,3'b101}, 8);

        // T2: tailed frame, o_ready low for the two tail cycles
        log_a.delete();
        send_frame(1'b0, t2_bits, 8);
        idle();
        @(negedge clk); chk("t2_rdy0", ifa.o_ready, 0);
        @(negedge clk); chk("t2_rdy1", ifa.o_ready, 0);
        @(negedge clk); chk("t2_rdy2", ifa.o_ready, 1);
        drain();
        chk_log("t2", 1'b0, {3'b000,3'b000,3'b110,3'b100,3'b000,3'b100,3'b110,3'b110,3'b100,3'b111}, 10);

        // T3: same frame under 1,0,0,1 backpressure
        log_a.delete();
        bp_idx = 0; bp_mode = 1;
        send_frame(1'b0, t2_bits, 8);
        idle(); drain();
        bp_mode = 0; drain();
        chk_log("t3", 1'b0, {3'b000,3'b000,3'b110,3'b100,3'b000,3'b100,3'b110,3'b110,3'b100,3'b111}, 10);

        // T4: reset after third accepted bit
        send(1'b0, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0); send(1'b0, 1'b1, 1'b0);
        idle();
        rst_n = 1'b0;
        #1 chk("t4_async", {ifa.o_valid, ifa.o_data, ifa.o_last, ifa.o_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        log_a.delete();
        send(1'b0, 1'b1, 1'b1);
        idle(); drain();
        chk_log("t4", 1'b0, {3'b110,3'b100,3'b111}, 3);

        // T5: back-to-back frames with i_valid held high
        log_a.delete();
        send(1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        idle(); drain();
        chk_log("t5", 1'b0, {3'b110,3'b100,3'b111,3'b110,3'b010,3'b010,3'b111}, 7);

        // Random frames, random gaps and random backpressure
        bp_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                send(1'b0, 1'($urandom_range(0, 1)), i == len - 1);
                if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
            end
            if ($urandom_range(0, 1) == 0) idle();
            send(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            idle();
        end
        send(1'b1, 1'b0, 1'b1);
        idle();
        bp_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
